// File: rtl/display_scan_scheduler.sv
// Scans a 3-digit common-anode 7-segment display.
//
// Each digit owns a slot of DWELL_CYCLES clocks: the first BLANK_CYCLES are dark to
// avoid ghosting, then the digit is driven for the rest of the slot. The BCD inputs,
// decimal-point requests and leading-zero mode are snapshotted once per frame
// (3 slots) so a frame never mixes old and new values.
//
// Ports:
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_enable         1 = scanning runs, 0 = display dark
//   i_digit0..2      BCD digits, digit0 least significant
//   i_dp             decimal point request per digit, 1 = lit
//   i_lz_suppress    1 = blank leading zeros
//   o_segmentEnable  active-low digit enables, bit k -> digit k
//   o_segments       active-low {dp,g,f,e,d,c,b,a}
//   o_frame_tick     one-cycle pulse in the cycle a new snapshot is in use
module display_scan_scheduler #(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [3:0] i_digit0,
  input  logic [3:0] i_digit1,
  input  logic [3:0] i_digit2,
  input  logic [2:0] i_dp,
  input  logic       i_lz_suppress,
  output logic [2:0] o_segmentEnable,
  output logic [7:0] o_segments,
  output logic       o_frame_tick
);

  localparam int unsigned CntW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      snap_d0_q, snap_d0_d;
  logic [3:0]      snap_d1_q, snap_d1_d;
  logic [3:0]      snap_d2_q, snap_d2_d;
  logic [2:0]      snap_dp_q, snap_dp_d;
  logic            snap_lz_q, snap_lz_d;
  logic [2:0]      seg_en_q, seg_en_d;
  logic [7:0]      segments_q, segments_d;
  logic            tick_q, tick_d;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] decode7(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase
    return seg;
  endfunction

  // Next-state: slot sequencing and frame snapshot.
  always_comb begin
    logic load;
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    snap_d0_d = snap_d0_q;
    snap_d1_d = snap_d1_q;
    snap_d2_d = snap_d2_q;
    snap_dp_d = snap_dp_q;
    snap_lz_d = snap_lz_q;
    load      = 1'b0;

    if (!i_enable) begin
      state_d = StIdle;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StBlank;
          idx_d   = 2'd0;
          cnt_d   = '0;
          load    = 1'b1;
        end
        StBlank: begin
          cnt_d = cnt_q + CntOne;
          if (cnt_q == BlankLast) state_d = StDrive;
        end
        StDrive: begin
          if (cnt_q == DwellLast) begin
            cnt_d   = '0;
            state_d = StBlank;
            // Index 3 is unreachable; treat it like 2 and wrap.
            if (idx_q >= 2'd2) begin
              idx_d = 2'd0;
              load  = 1'b1;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end

    if (load) begin
      snap_d0_d = i_digit0;
      snap_d1_d = i_digit1;
      snap_d2_d = i_digit2;
      snap_dp_d = i_dp;
      snap_lz_d = i_lz_suppress;
    end
    tick_d = load;
  end

  // Outputs are computed from next-state values so the registered pins line up
  // with the state they belong to.
  always_comb begin
    logic [3:0] digit;
    logic       blank;
    logic       dp;
    seg_en_d   = 3'b111;
    segments_d = 8'hFF;
    digit      = snap_d0_d;
    blank      = 1'b0;
    dp         = snap_dp_d[0];
    case (idx_d)
      2'd1: begin
        digit = snap_d1_d;
        blank = snap_lz_d && (snap_d2_d == 4'd0) && (snap_d1_d == 4'd0);
        dp    = snap_dp_d[1];
      end
      2'd2: begin
        digit = snap_d2_d;
        blank = snap_lz_d && (snap_d2_d == 4'd0);
        dp    = snap_dp_d[2];
      end
      default: begin
        digit = snap_d0_d;
        blank = 1'b0;
        dp    = snap_dp_d[0];
      end
    endcase
    if (state_d == StDrive) begin
      case (idx_d)
        2'd1:    seg_en_d = 3'b101;
        2'd2:    seg_en_d = 3'b011;
        default: seg_en_d = 3'b110;
      endcase
      // A blanked digit keeps its enable and its decimal point.
      segments_d = {~dp, blank ? 7'h7F : decode7(digit)};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      snap_d0_q  <= 4'd0;
      snap_d1_q  <= 4'd0;
      snap_d2_q  <= 4'd0;
      snap_dp_q  <= 3'd0;
      snap_lz_q  <= 1'b0;
      seg_en_q   <= 3'b111;
      segments_q <= 8'hFF;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      snap_d0_q  <= snap_d0_d;
      snap_d1_q  <= snap_d1_d;
      snap_d2_q  <= snap_d2_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
      seg_en_q   <= seg_en_d;
      segments_q <= segments_d;
      tick_q     <= tick_d;
    end
  end

  assign o_segmentEnable = seg_en_q;
  assign o_segments      = segments_q;
  assign o_frame_tick    = tick_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler with DWELL=8, BLANK=2. A frame-phase model
// predicts every output on every falling edge; directed literal checks pin it.
module tb_display_scan_scheduler;

  localparam int Dwell = 8;
  localparam int Blank = 2;
  localparam int Frame = 3 * Dwell;
  localparam logic [7:0] SegTab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0;
  logic [2:0] dp = 3'd0;
  logic       lz = 1'b0;
  logic [2:0] seg_en;
  logic [7:0] segs;
  logic       tick;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic chk_on = 1'b0;

  // Model state: running flag, phase within frame, and frame snapshot.
  logic       m_run;
  int         m_phase;
  logic [3:0] m_d [3];
  logic [2:0] m_dp;
  logic       m_lz;

  display_scan_scheduler #(
    .DWELL_CYCLES(Dwell),
    .BLANK_CYCLES(Blank)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_digit0       (d0),
    .i_digit1       (d1),
    .i_digit2       (d2),
    .i_dp           (dp),
    .i_lz_suppress  (lz),
    .o_segmentEnable(seg_en),
    .o_segments     (segs),
    .o_frame_tick   (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [2:0] en, input logic [7:0] sg,
                         input logic tk);
    check({name, ".en"}, {5'd0, seg_en}, {5'd0, en});
    check({name, ".seg"}, segs, sg);
    check({name, ".tick"}, {7'd0, tick}, {7'd0, tk});
  endtask

  task automatic goto(input int c);
    repeat (c - cyc) @(negedge clk);
    cyc = c;
  endtask

  // Model: a frame is Frame cycles from the tick; the snapshot is taken on the
  // edge that starts the frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run   <= 1'b0;
      m_phase <= 0;
    end else if (!enable) begin
      m_run   <= 1'b0;
      m_phase <= 0;
    end else if (!m_run || m_phase == Frame - 1) begin
      m_run   <= 1'b1;
      m_phase <= 0;
      m_d[0]  <= d0;
      m_d[1]  <= d1;
      m_d[2]  <= d2;
      m_dp    <= dp;
      m_lz    <= lz;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  function automatic logic [7:0] model_seg(input int slot);
    logic blank;
    logic [7:0] s;
    blank = 1'b0;
    if (slot == 2) blank = m_lz && (m_d[2] == 4'd0);
    if (slot == 1) blank = m_lz && (m_d[2] == 4'd0) && (m_d[1] == 4'd0);
    s = SegTab[m_d[slot]];
    if (blank) s = 8'hFF;
    if (m_dp[slot]) s[7] = 1'b0;
    return s;
  endfunction

  always @(negedge clk) begin
    int slot;
    logic [2:0] een;
    logic [7:0] eseg;
    logic etick;
    if (chk_on) begin
      een = 3'b111;
      eseg = 8'hFF;
      etick = 1'b0;
      if (m_run) begin
        slot = m_phase / Dwell;
        etick = (m_phase == 0);
        if ((m_phase % Dwell) >= Blank) begin
          een[slot] = 1'b0;
          eseg = model_seg(slot);
        end
      end
      check("model.en", {5'd0, seg_en}, {5'd0, een});
      check("model.seg", segs, eseg);
      check("model.tick", {7'd0, tick}, {7'd0, etick});
    end
  end

  initial begin
    d0 = 4'd3; d1 = 4'd2; d2 = 4'd1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    chk_out("reset", 3'b111, 8'hFF, 1'b0);
    rst_n = 1'b1;
    enable = 1'b1;
    cyc = -1;

    // Basic scan of 3/2/1.
    goto(0);  chk_out("first_tick", 3'b111, 8'hFF, 1'b1);
    goto(1);  chk_out("blank0b", 3'b111, 8'hFF, 1'b0);
    goto(2);  chk_out("d0_first", 3'b110, 8'hB0, 1'b0);
    goto(7);  chk_out("d0_last", 3'b110, 8'hB0, 1'b0);
    goto(8);  chk_out("blank1", 3'b111, 8'hFF, 1'b0);
    goto(10); chk_out("d1", 3'b101, 8'hA4, 1'b0);
    goto(16); chk_out("blank2", 3'b111, 8'hFF, 1'b0);
    goto(18); chk_out("d2", 3'b011, 8'hF9, 1'b0);
    goto(23); chk_out("d2_last", 3'b011, 8'hF9, 1'b0);
    goto(24); chk_out("second_tick", 3'b111, 8'hFF, 1'b1);

    // Leading-zero suppression with dp on digit0.
    d0 = 4'd5; d1 = 4'd0; d2 = 4'd0; lz = 1'b1; dp = 3'b001;
    goto(48); chk_out("lz_tick", 3'b111, 8'hFF, 1'b1);
    goto(50); chk_out("lz_d0", 3'b110, 8'h12, 1'b0);
    goto(58); chk_out("lz_d1", 3'b101, 8'hFF, 1'b0);
    goto(66); chk_out("lz_d2", 3'b011, 8'hFF, 1'b0);
    lz = 1'b0;
    goto(74); chk_out("nolz_d0", 3'b110, 8'h12, 1'b0);
    goto(82); chk_out("nolz_d1", 3'b101, 8'hC0, 1'b0);
    goto(90); chk_out("nolz_d2", 3'b011, 8'hC0, 1'b0);

    // Mid-frame change of digit0 must wait for the next frame.
    d0 = 4'd4; dp = 3'b000;
    goto(98);  chk_out("d0_is4", 3'b110, 8'h99, 1'b0);
    goto(108); d0 = 4'd7;
    goto(110); chk_out("mid_d1", 3'b101, 8'hC0, 1'b0);
    goto(118); chk_out("mid_d2", 3'b011, 8'hC0, 1'b0);
    goto(120); chk_out("tick_after_chg", 3'b111, 8'hFF, 1'b1);
    goto(122); chk_out("d0_is7", 3'b110, 8'hF8, 1'b0);

    // Non-BCD digit shows a dash, with and without dp.
    d1 = 4'hC;
    goto(154); chk_out("dash", 3'b101, 8'hBF, 1'b0);
    dp = 3'b010;
    goto(170); chk_out("dp_d0_off", 3'b110, 8'hF8, 1'b0);
    goto(178); chk_out("dash_dp", 3'b101, 8'h3F, 1'b0);

    // Drop enable during digit1 drive.
    goto(180); enable = 1'b0;
    goto(181); chk_out("disabled", 3'b111, 8'hFF, 1'b0);
    goto(183); chk_out("idle", 3'b111, 8'hFF, 1'b0);
    enable = 1'b1;
    goto(184); chk_out("reenable_tick", 3'b111, 8'hFF, 1'b1);
    goto(186); chk_out("reenable_d0", 3'b110, 8'hF8, 1'b0);

    // Asynchronous reset between edges while digit0 is driven.
    #2 rst_n = 1'b0;
    #1 chk_out("async_reset", 3'b111, 8'hFF, 1'b0);
    @(negedge clk);
    cyc = 187;
    rst_n = 1'b1;
    goto(188); chk_out("post_reset_tick", 3'b111, 8'hFF, 1'b1);
    goto(190); chk_out("post_reset_d0", 3'b110, 8'hF8, 1'b0);
    goto(215);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
